// File: rtl/btn_input.sv
// Debounced push-button/switch input peripheral with a small register interface.
// Each input is synchronized and debounced. A debounced 0->1 edge sets a sticky pending bit.
module btn_input #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn,
    input  logic             sel,
    input  logic             we,
    input  logic [3:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             irq
);

    localparam int unsigned     CW     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CntMax = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] state_q, state_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] irq_en_q, irq_en_d;
    logic [WIDTH-1:0] rise;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;
    logic             wr_en, rd_en;
    logic             unused_bits;

    assign wr_en       = sel & we;
    assign rd_en       = sel & ~we;
    assign unused_bits = ^{addr[1:0], wdata};

    // A bit flips only after the synchronized input has disagreed with it on
    // DEBOUNCE_CYCLES consecutive edges; any agreeing edge restarts the count.
    always_comb begin
        state_d = state_q;
        rise    = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != state_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    state_d[i] = ~state_q[i];
                    rise[i]    = ~state_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        pend_d   = pend_q;
        irq_en_d = irq_en_q;
        rdata_d  = rdata_q;
        irq_d    = |(pend_q & irq_en_q);
        if (wr_en) begin
            case (addr[3:2])
                2'd1:    pend_d   = pend_q & ~wdata[WIDTH-1:0];
                2'd2:    irq_en_d = wdata[WIDTH-1:0];
                default: ;
            endcase
        end
        // New rising edges win over a simultaneous clear.
        pend_d = pend_d | rise;
        if (rd_en) begin
            rdata_d = '0;
            case (addr[3:2])
                2'd0:    rdata_d[WIDTH-1:0] = state_q;
                2'd1:    rdata_d[WIDTH-1:0] = pend_q;
                2'd2:    rdata_d[WIDTH-1:0] = irq_en_q;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            state_q  <= '0;
            pend_q   <= '0;
            irq_en_q <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q  <= btn;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            pend_q   <= pend_d;
            irq_en_q <= irq_en_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
            for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign rdata = rdata_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_btn_input.sv
// Directed bench for btn_input. A window-based reference model tracks the expected
// rdata and irq values on every cycle. Literal checks pin the key scenarios.
module tb_btn_input;

    localparam int W = 4;
    localparam int D = 4;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  btn   = '0;
    logic          sel   = 1'b0;
    logic          we    = 1'b0;
    logic [3:0]    addr  = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    btn_input #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: h[0] is the newest raw btn sample. The debounce logic sees the sample
    // taken two edges earlier. A bit flips once the last D such samples all differ from it.
    logic [W-1:0] h [D+2];
    logic [W-1:0] m_state = '0;
    logic [W-1:0] m_pend  = '0;
    logic [W-1:0] m_en    = '0;
    logic [31:0]  m_rdata = '0;
    logic         m_irq   = 1'b0;
    logic [W-1:0] m_next, m_rise;
    logic         m_alld;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < D + 2; j++) h[j] = '0;
            m_state = '0;
            m_pend  = '0;
            m_en    = '0;
            m_rdata = '0;
            m_irq   = 1'b0;
        end else begin
            for (int j = D + 1; j > 0; j--) h[j] = h[j-1];
            h[0]   = btn;
            m_next = m_state;
            for (int i = 0; i < W; i++) begin
                m_alld = 1'b1;
                for (int j = 2; j <= D + 1; j++) if (h[j][i] == m_state[i]) m_alld = 1'b0;
                if (m_alld) m_next[i] = ~m_state[i];
            end
            m_rise = m_next & ~m_state;
            m_irq  = |(m_pend & m_en);
            if (sel && !we) begin
                m_rdata = 32'(addr[3:2] == 2'd0 ? m_state :
                              addr[3:2] == 2'd1 ? m_pend  :
                              addr[3:2] == 2'd2 ? m_en    : W'(0));
            end
            if (sel && we && addr[3:2] == 2'd1) m_pend = m_pend & ~wdata[W-1:0];
            if (sel && we && addr[3:2] == 2'd2) m_en = wdata[W-1:0];
            m_pend  = m_pend | m_rise;
            m_state = m_next;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("model_rdata", rdata, m_rdata);
            check("model_irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        sel = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        sel = 1'b0;
        check(name, rdata, exp);
    endtask

    initial begin
        cyc(2);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);

        // Held button from reset release: state visible to a read issued on edge 7.
        btn = 4'b0001; sel = 1'b1; we = 1'b0; addr = 4'h0; reset = 1'b1;
        cyc(6);
        check("state_edge6_read_old", rdata, 32'h0);
        cyc(1);
        check("state_after_6", rdata, 32'h1);
        sel = 1'b0;
        rd_chk("pend_set", 4'h4, 32'h1);

        // Enable and clear the interrupt.
        wr(4'h8, 32'h1);
        check("irq_before", 32'(irq), 32'h0);
        cyc(1);
        check("irq_on", 32'(irq), 32'h1);
        wr(4'h4, 32'h1);
        check("irq_hold", 32'(irq), 32'h1);
        cyc(1);
        check("irq_off", 32'(irq), 32'h0);
        rd_chk("pend_clr", 4'h4, 32'h0);

        // Three-cycle glitch on bit 1 is rejected.
        btn = 4'b0011; cyc(3);
        btn = 4'b0001; cyc(10);
        rd_chk("glitch_state", 4'h0, 32'h1);
        rd_chk("glitch_pend", 4'h4, 32'h0);

        // Upper wdata bits dropped; enable bit 2 only.
        wr(4'h8, 32'hFFFF_FFF4);
        rd_chk("en_mask", 4'h8, 32'h4);
        btn = 4'b0101; cyc(8);
        check("irq_b2", 32'(irq), 32'h1);
        btn = 4'b0001; cyc(8);
        check("irq_after_fall", 32'(irq), 32'h1);
        // Clear bit 2 on the same edge as its next rise: set wins.
        btn = 4'b0101; cyc(5);
        wr(4'h4, 32'h4);
        check("irq_setwins", 32'(irq), 32'h1);
        rd_chk("pend_setwins", 4'h4, 32'h4);

        // Falling edge leaves pend; reserved reads zero; STATE is read-only.
        btn = 4'b0100; cyc(8);
        rd_chk("fall_state", 4'h0, 32'h4);
        rd_chk("fall_pend", 4'h4, 32'h4);
        rd_chk("rsvd", 4'hC, 32'h0);
        wr(4'h0, 32'hF);
        rd_chk("ro_state", 4'h0, 32'h4);
        check("irq_still", 32'(irq), 32'h1);

        // Asynchronous reset mid-count with irq high.
        btn = 4'b0110; cyc(3);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_rdata", rdata, 32'h0);
        check("async_irq", 32'(irq), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc(8);
        rd_chk("post_rst_state", 4'h0, 32'h6);
        rd_chk("post_rst_pend", 4'h4, 32'h6);
        check("post_rst_irq", 32'(irq), 32'h0);
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_input.md
BTN_INPUT -- requirements
Module: btn_input

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the number of push-button/switch input bits.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the consecutive stable cycles needed to accept a level change; legal range 2..2^24.
REQ-003 SHALL have port clk, input, 1, system clock; all state is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port btn, input, WIDTH, raw asynchronous board inputs.
REQ-006 SHALL have port sel, input, 1, bus access strobe for this peripheral.
REQ-007 SHALL have port we, input, 1, write enable; 1 = write, 0 = read, qualified by sel.
REQ-008 SHALL have port addr, input, 4, byte address; only bits [3:2] decoded.
REQ-009 SHALL have port wdata, input, 32, write data.
REQ-010 SHALL have port rdata, output, 32, registered read data.
REQ-011 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-012 SHALL pass each btn bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL keep a per-bit debounced state (state) and a per-bit counter of at least ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-014 SHALL clear a bit's counter on any edge where synchronized bit equals state.
REQ-015 SHALL increment a bit's counter on each edge where synchronized bit differs from state and counter < DEBOUNCE_CYCLES-1.
REQ-016 SHALL, on an edge where the bit differs and counter == DEBOUNCE_CYCLES-1, toggle state and clear the counter; total latency btn change -> state change = 2 + DEBOUNCE_CYCLES edges.
REQ-017 SHALL restart the count from 0 whenever a glitch returns the synchronized bit to state before acceptance; no counter wrap-around.
REQ-018 SHALL set pend[i] on the edge where state[i] transitions 0->1 (rising edge only; 1->0 sets nothing).
REQ-019 SHALL decode registers by addr[3:2]: 0 = STATE (RO, bits [WIDTH-1:0]), 1 = PEND (W1C), 2 = IRQ_EN (RW), 3 = reserved (reads 0, writes ignored).
REQ-020 SHALL load rdata on the edge where sel=1 and we=0, from the selected register, upper bits zero; rdata holds its value otherwise; read latency 1 cycle.
REQ-021 SHALL apply writes on the edge where sel=1 and we=1; writes to STATE ignored.
REQ-022 SHALL, when a PEND W1C and a new rising edge on the same bit coincide, leave pend[i]=1 (set wins).
REQ-023 SHALL drive irq registered: irq = |(pend & irq_en), updated one edge after pend or irq_en changes.
REQ-024 SHALL ignore wdata bits above WIDTH-1.

Reset
REQ-025 SHALL, while reset=0, asynchronously force sync flops, state, counters, pend, irq_en, rdata and irq to 0.
REQ-026 SHALL resume debouncing from zero after reset deasserts; a btn already held high produces state=1 and pend=1 after 2 + DEBOUNCE_CYCLES edges.
REQ-027 SHALL, on reset asserted mid-count, discard any partial count with no state or pend change.

Verification (DEBOUNCE_CYCLES=4, WIDTH=4)
REQ-028 SHALL cover: btn=0001 held from reset release -> state=0001 exactly 6 edges later, pend=0001; read addr 0x0 -> rdata=0x00000001 next cycle.
REQ-029 SHALL cover: btn[1] high for 3 cycles then low -> state, pend stay 0000; counter returns to 0.
REQ-030 SHALL cover: pend=0001, write IRQ_EN=0x1 -> irq=1 one edge later; write PEND=0x1 -> pend=0000, irq=0 one edge later.
REQ-031 SHALL cover: W1C to PEND bit 2 on the same edge state[2] rises -> pend[2]=1 and irq stays 1 with IRQ_EN bit 2 set.
REQ-032 SHALL cover: state=0001 then btn[0] low -> state=0000 after 6 edges, pend unchanged; read addr 0xC -> rdata=0; write to 0x0 leaves state unchanged.
REQ-033 SHALL cover: reset pulsed low for 1 cycle mid-count and with irq=1 -> all outputs 0 immediately, without waiting for clk.
